// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_pkg
// Brief   : Shared types and constants for the iterative RV32M mul/div unit.
// Revision: 1.0
// ============================================================================
package muldiv_pkg;

    localparam int XLEN       = 32;
    localparam int ITERATIONS = 32;
    localparam int CNT_W      = $clog2(ITERATIONS);

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_div_step.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_div_step
// Brief   : One combinational restoring-divide step on 32-bit magnitudes.
// Revision: 1.0
// ============================================================================
module muldiv_div_step
    import muldiv_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic            i_bit,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic            o_qbit
);

    logic [XLEN:0] w_diff;

    // The borrow out of the 33-bit trial subtraction decides restore vs. keep.
    always_comb begin
        w_diff = {i_rem, i_bit} - {1'b0, i_divisor};
        o_qbit = ~w_diff[XLEN];
        o_rem  = o_qbit ? w_diff[XLEN-1:0] : {i_rem[XLEN-2:0], i_bit};
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_unit
// Brief   : Fixed-latency iterative RV32M multiply/divide unit (32 iterations).
// Revision: 1.0
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      OP,
    input  logic [XLEN-1:0] OPERAND_A,
    input  logic [XLEN-1:0] OPERAND_B,
    input  logic [4:0]      DEST_ADDR,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            RESULT_VALID,
    output logic [XLEN-1:0] RESULT,
    output logic [4:0]      RESULT_ADDR,
    output logic            WRITE
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_e               op_q, op_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, m_q, m_d;
    logic              neg_q, neg_d, dz_q, dz_d;
    logic [4:0]        addr_q, addr_d, result_addr_q, result_addr_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              valid_q, valid_d, write_q, write_d;

    logic              w_sa, w_sb;
    logic [XLEN:0]     w_sum;
    logic [XLEN-1:0]   w_div_rem;
    logic              w_div_qbit;
    logic [XLEN-1:0]   w_hi_nxt, w_lo_nxt, w_final;
    logic [2*XLEN-1:0] w_prod, w_prod_s;

    muldiv_div_step u_div_step (
        .i_rem     (hi_q),
        .i_bit     (lo_q[XLEN-1]),
        .i_divisor (m_q),
        .o_rem     (w_div_rem),
        .o_qbit    (w_div_qbit)
    );

    // hi/lo double as product {hi,lo} for multiply and {remainder,quotient} for divide.
    always_comb begin
        w_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});
        if (op_q[2]) begin
            w_hi_nxt = w_div_rem;
            w_lo_nxt = {lo_q[XLEN-2:0], w_div_qbit};
        end else begin
            w_hi_nxt = w_sum[XLEN:1];
            w_lo_nxt = {w_sum[0], lo_q[XLEN-1:1]};
        end
        w_prod   = {w_hi_nxt, w_lo_nxt};
        w_prod_s = neg_q ? (~w_prod + 1'b1) : w_prod;
        case (op_q)
            OP_MUL:                       w_final = w_prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_final = dz_q ? {XLEN{1'b1}} : magnitude(w_lo_nxt, neg_q);
            default:                      w_final = magnitude(w_hi_nxt, neg_q);
        endcase
    end

    assign w_sa = OPERAND_A[XLEN-1] &
                  (OP == OP_MULH || OP == OP_MULHSU || OP == OP_DIV || OP == OP_REM);
    assign w_sb = OPERAND_B[XLEN-1] & (OP == OP_MULH || OP == OP_DIV || OP == OP_REM);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        m_d           = m_q;
        neg_d         = neg_q;
        dz_d          = dz_q;
        addr_d        = addr_q;
        result_d      = result_q;
        result_addr_d = result_addr_q;
        valid_d       = 1'b0;
        write_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START && !FLUSH) begin
                    state_d = ST_CALC;
                    cnt_d   = '0;
                    op_d    = op_e'(OP);
                    addr_d  = DEST_ADDR;
                    hi_d    = '0;
                    lo_d    = OP[2] ? magnitude(OPERAND_A, w_sa) : magnitude(OPERAND_B, w_sb);
                    m_d     = OP[2] ? magnitude(OPERAND_B, w_sb) : magnitude(OPERAND_A, w_sa);
                    // Remainder follows the dividend sign; everything else follows sign XOR.
                    neg_d   = (OP == OP_REM) ? w_sa : (w_sa ^ w_sb);
                    dz_d    = (OPERAND_B == '0);
                end
            end
            ST_CALC: begin
                if (FLUSH) begin
                    state_d = ST_IDLE;
                end else begin
                    hi_d  = w_hi_nxt;
                    lo_d  = w_lo_nxt;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITERATIONS - 1)) begin
                        state_d       = ST_DONE;
                        result_d      = w_final;
                        result_addr_d = addr_q;
                        valid_d       = 1'b1;
                        write_d       = (addr_q != 5'd0);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            op_q          <= OP_MUL;
            hi_q          <= '0;
            lo_q          <= '0;
            m_q           <= '0;
            neg_q         <= 1'b0;
            dz_q          <= 1'b0;
            addr_q        <= '0;
            result_q      <= '0;
            result_addr_q <= '0;
            valid_q       <= 1'b0;
            write_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            m_q           <= m_d;
            neg_q         <= neg_d;
            dz_q          <= dz_d;
            addr_q        <= addr_d;
            result_q      <= result_d;
            result_addr_q <= result_addr_d;
            valid_q       <= valid_d;
            write_q       <= write_d;
        end
    end

    assign BUSY         = (state_q != ST_IDLE);
    assign RESULT_VALID = valid_q;
    assign WRITE        = write_q;
    assign RESULT       = result_q;
    assign RESULT_ADDR  = result_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_muldiv_unit
// Brief   : Directed self-checking bench for muldiv_unit.
// Revision: 1.0
// ============================================================================
module tb_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        FLUSH = 1'b0;
    logic [2:0]  OP = 3'b000;
    logic [31:0] OPERAND_A = 32'd0;
    logic [31:0] OPERAND_B = 32'd0;
    logic [4:0]  DEST_ADDR = 5'd0;
    logic        BUSY, RESULT_VALID, WRITE;
    logic [31:0] RESULT;
    logic [4:0]  RESULT_ADDR;

    int tests_run = 0;
    int tests_failed = 0;

    muldiv_unit dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .START        (START),
        .OP           (OP),
        .OPERAND_A    (OPERAND_A),
        .OPERAND_B    (OPERAND_B),
        .DEST_ADDR    (DEST_ADDR),
        .FLUSH        (FLUSH),
        .BUSY         (BUSY),
        .RESULT_VALID (RESULT_VALID),
        .RESULT       (RESULT),
        .RESULT_ADDR  (RESULT_ADDR),
        .WRITE        (WRITE)
    );

    always #5 CLK = ~CLK;

    // Issues one operation and watches 40 edges after the START edge.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res, output int lat,
                         output int nvalid, output logic wr);
        @(negedge CLK);
        START = 1'b1; OP = op; OPERAND_A = a; OPERAND_B = b; DEST_ADDR = rd;
        @(posedge CLK); #1;
        START = 1'b0;
        lat = -1; nvalid = 0; res = 'x; wr = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(posedge CLK); #1;
            if (RESULT_VALID) begin
                nvalid++;
                if (lat < 0) begin
                    lat = k; res = RESULT; wr = WRITE;
                end
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge CLK);
        #1;
        tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        tests_run++; if (RESULT_VALID !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", RESULT_VALID); end
        tests_run++; if (WRITE !== 1'b0) begin tests_failed++; $display("FAIL reset_write: got %b expected 0", WRITE); end
        tests_run++; if (RESULT !== 32'h0) begin tests_failed++; $display("FAIL reset_result: got %h expected 00000000", RESULT); end
        tests_run++; if (RESULT_ADDR !== 5'd0) begin tests_failed++; $display("FAIL reset_addr: got %0d expected 0", RESULT_ADDR); end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_mul;
        logic [31:0] res; int lat; int nv; logic wr;
        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, res, lat, nv, wr);
        tests_run++; if (res !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL mul_result: got %h expected ffffffeb", res); end
        tests_run++; if (lat !== 32) begin tests_failed++; $display("FAIL mul_latency: got %0d expected 32", lat); end
        tests_run++; if (nv !== 1) begin tests_failed++; $display("FAIL mul_valid_count: got %0d expected 1", nv); end
        tests_run++; if (wr !== 1'b1) begin tests_failed++; $display("FAIL mul_write: got %b expected 1", wr); end
        tests_run++; if (RESULT !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL mul_hold: got %h expected ffffffeb", RESULT); end
        tests_run++; if (RESULT_ADDR !== 5'd5) begin tests_failed++; $display("FAIL mul_addr: got %0d expected 5", RESULT_ADDR); end
    endtask

    task automatic test_mulh;
        logic [2:0]  ops [3] = '{3'b001, 3'b011, 3'b010};
        logic [31:0] av  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bv  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex  [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] res; int lat; int nv; logic wr;
        for (int i = 0; i < 3; i++) begin
            do_op(ops[i], av[i], bv[i], 5'd1, res, lat, nv, wr);
            tests_run++;
            if (res !== ex[i] || lat !== 32) begin
                tests_failed++;
                $display("FAIL mulh_%0d: got %h at %0d expected %h at 32", i, res, lat, ex[i]);
            end
        end
    endtask

    task automatic test_div;
        logic [2:0]  ops [8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
        logic [31:0] av  [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv  [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex  [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] res; int lat; int nv; logic wr;
        for (int i = 0; i < 8; i++) begin
            do_op(ops[i], av[i], bv[i], 5'd2, res, lat, nv, wr);
            tests_run++;
            if (res !== ex[i] || lat !== 32 || nv !== 1) begin
                tests_failed++;
                $display("FAIL div_%0d: got %h at %0d (x%0d) expected %h at 32 (x1)", i, res, lat, nv, ex[i]);
            end
        end
    endtask

    task automatic test_rd_zero;
        logic [31:0] res; int lat; int nv; logic wr;
        do_op(3'b000, 32'd6, 32'd7, 5'd0, res, lat, nv, wr);
        tests_run++; if (lat !== 32 || res !== 32'd42) begin tests_failed++; $display("FAIL rd0_valid: got %h at %0d expected 0000002a at 32", res, lat); end
        tests_run++; if (wr !== 1'b0) begin tests_failed++; $display("FAIL rd0_write: got %b expected 0", wr); end
    endtask

    task automatic test_start_ignored;
        int lat = -1; int nv = 0; logic [31:0] res = 'x;
        @(negedge CLK);
        START = 1'b1; OP = 3'b101; OPERAND_A = 32'd100; OPERAND_B = 32'd7; DEST_ADDR = 5'd3;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        START = 1'b1; OP = 3'b000; OPERAND_A = 32'd3; OPERAND_B = 32'd3; DEST_ADDR = 5'd9;
        for (int k = 4; k <= 40; k++) begin
            @(posedge CLK); #1;
            START = 1'b0;
            if (RESULT_VALID) begin
                nv++;
                if (lat < 0) begin lat = k; res = RESULT; end
            end
        end
        tests_run++; if (res !== 32'd14 || lat !== 32) begin tests_failed++; $display("FAIL ignore_start_result: got %h at %0d expected 0000000e at 32", res, lat); end
        tests_run++; if (nv !== 1 || BUSY !== 1'b0) begin tests_failed++; $display("FAIL ignore_start_queued: got %0d results busy %b expected 1 result busy 0", nv, BUSY); end
        tests_run++; if (RESULT_ADDR !== 5'd3) begin tests_failed++; $display("FAIL ignore_start_addr: got %0d expected 3", RESULT_ADDR); end
    endtask

    task automatic test_flush;
        logic [31:0] prev; logic [31:0] res; int lat; int nv; logic wr;
        prev = RESULT;
        @(negedge CLK);
        START = 1'b1; OP = 3'b011; OPERAND_A = 32'hFFFF_FFFF; OPERAND_B = 32'hFFFF_FFFF; DEST_ADDR = 5'd7;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        FLUSH = 1'b1;
        @(posedge CLK); #1;
        tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL flush_busy: got %b expected 0", BUSY); end
        tests_run++; if (RESULT_VALID !== 1'b0 || RESULT !== prev) begin tests_failed++; $display("FAIL flush_result: got %h valid %b expected %h valid 0", RESULT, RESULT_VALID, prev); end
        FLUSH = 1'b0;
        do_op(3'b101, 32'd100, 32'd7, 5'd4, res, lat, nv, wr);
        tests_run++; if (res !== 32'd14 || lat !== 32 || nv !== 1) begin tests_failed++; $display("FAIL flush_restart: got %h at %0d (x%0d) expected 0000000e at 32 (x1)", res, lat, nv); end
        @(negedge CLK);
        START = 1'b1; FLUSH = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; FLUSH = 1'b0;
        tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL flush_over_start: got busy %b expected 0", BUSY); end
    endtask

    task automatic test_reset_mid;
        int nv = 0;
        @(negedge CLK);
        START = 1'b1; OP = 3'b100; OPERAND_A = 32'd1000; OPERAND_B = 32'd3; DEST_ADDR = 5'd8;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (15) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        tests_run++; if (BUSY !== 1'b0 || RESULT_VALID !== 1'b0 || WRITE !== 1'b0) begin tests_failed++; $display("FAIL midreset_ctrl: got busy %b valid %b write %b expected 0 0 0", BUSY, RESULT_VALID, WRITE); end
        tests_run++; if (RESULT !== 32'h0 || RESULT_ADDR !== 5'd0) begin tests_failed++; $display("FAIL midreset_data: got %h addr %0d expected 00000000 addr 0", RESULT, RESULT_ADDR); end
        @(negedge CLK);
        RESET = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK); #1;
            if (RESULT_VALID) nv++;
        end
        tests_run++; if (nv !== 0 || BUSY !== 1'b0) begin tests_failed++; $display("FAIL midreset_discard: got %0d results busy %b expected 0 busy 0", nv, BUSY); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_rd_zero();
        test_start_ignored();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
